uart_boot_loader: RTL

UART-driven program loader that sits between the on-chip UART receive/transmit byte handshakes and the DMA master port of the IDS bus. It parses a simple framed byte protocol from the host, assembles little-endian 32-bit words and writes them through the DMA port into IMEM/DMEM. It holds the core in reset until the host issues a RUN command, and acknowledges every frame with ACK/NAK bytes over UART TX.

---
 rtl/uart_boot_loader_if.sv | 30 +++
 rtl/uart_boot_loader.sv | 136 +++++++++++++
 2 files changed

// File: rtl/uart_boot_loader_if.sv
// rtl/uart_boot_loader_if.sv - UART byte streams and DMA master port of the boot loader
interface uart_boot_loader_if #(
    parameter int XLEN = 32
);
    logic [7:0]      rx_tdata;
    logic            rx_tvalid;
    logic            rx_tready;
    logic [7:0]      tx_tdata;
    logic            tx_tvalid;
    logic            tx_tready;
    logic            req_dma;
    logic            gnt_dma;
    logic [XLEN-1:0] dma_addr;
    logic            dma_write;
    logic            dma_read;
    logic [3:0]      dma_size;
    logic [XLEN-1:0] dma_din;

    modport master (
        input  rx_tdata, rx_tvalid, tx_tready, gnt_dma,
        output rx_tready, tx_tdata, tx_tvalid,
        output req_dma, dma_addr, dma_write, dma_read, dma_size, dma_din
    );

    modport slave (
        output rx_tdata, rx_tvalid, tx_tready, gnt_dma,
        input  rx_tready, tx_tdata, tx_tvalid,
        input  req_dma, dma_addr, dma_write, dma_read, dma_size, dma_din
    );
endinterface

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - framed UART program loader writing words over DMA
// Holds the core in reset until a RUN frame; answers every frame with ACK/NAK.
module uart_boot_loader #(
    parameter int TIMEOUT_CYCLES = 100_000_000,
    parameter int XLEN           = 32
) (
    input  logic              clk,
    input  logic              rst,
    uart_boot_loader_if.master bus,
    output logic              core_rst,
    output logic              busy
);
    localparam logic [7:0] SYNC = 8'hA5;
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;
    localparam int         TW   = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_HDR, S_DATA, S_BUS, S_CHK, S_RESP
    } state_t;

    state_t          state, state_nx;
    logic [2:0]      cnt;
    logic [XLEN-1:2] addr_w;
    logic [XLEN-1:0] word;
    logic [15:0]     len;
    logic [7:0]      sum;
    logic [7:0]      tx_byte;
    logic [7:0]      resp_nx;
    logic [TW-1:0]   timer;
    logic            in_frame;
    logic            rx_fire;
    logic            timed_out;
    logic [7:0]      rx_b;

    assign rx_b      = bus.rx_tdata;
    assign in_frame  = (state == S_CMD) || (state == S_HDR) ||
                       (state == S_DATA) || (state == S_CHK);
    assign rx_fire   = bus.rx_tvalid && bus.rx_tready;
    assign timed_out = in_frame && !rx_fire && (timer == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        resp_nx  = NAK;
        case (state)
            S_IDLE: if (rx_fire && rx_b == SYNC) state_nx = S_CMD;
            S_CMD: begin
                if (rx_fire) begin
                    if (rx_b == 8'h01) begin
                        state_nx = S_HDR;
                    end else begin
                        state_nx = S_RESP;
                        if (rx_b == 8'h02) resp_nx = ACK;
                    end
                end
            end
            // Last header byte is the LEN high byte; decide on the assembled length.
            S_HDR: if (rx_fire && cnt == 3'd5)
                       state_nx = ({rx_b, len[7:0]} != 16'd0) ? S_DATA : S_CHK;
            S_DATA: if (rx_fire && cnt == 3'd3) state_nx = S_BUS;
            S_BUS:  if (bus.gnt_dma) state_nx = (len != 16'd1) ? S_DATA : S_CHK;
            S_CHK: begin
                if (rx_fire) begin
                    state_nx = S_RESP;
                    if (rx_b == sum) resp_nx = ACK;
                end
            end
            S_RESP: if (bus.tx_tready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (timed_out) state_nx = S_RESP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            addr_w   <= '0;
            word     <= '0;
            len      <= '0;
            sum      <= '0;
            tx_byte  <= '0;
            timer    <= '0;
            core_rst <= 1'b1;
        end else begin
            if (state != state_nx)  cnt <= '0;
            else if (rx_fire)       cnt <= cnt + 3'd1;

            if (state != state_nx || rx_fire) timer <= '0;
            else if (in_frame)                timer <= timer + TW'(1);

            if (state_nx == S_RESP && state != S_RESP) tx_byte <= resp_nx;

            if (state == S_CMD && rx_fire && rx_b == 8'h02) core_rst <= 1'b0;

            if (state == S_CMD && state_nx == S_HDR)
                sum <= '0;
            else if (rx_fire && (state == S_HDR || state == S_DATA))
                sum <= sum + rx_b;

            // Address low two bits are dropped: writes are always word aligned.
            if (state == S_HDR && rx_fire) begin
                case (cnt)
                    3'd0:    addr_w[7:2]   <= rx_b[7:2];
                    3'd1:    addr_w[15:8]  <= rx_b;
                    3'd2:    addr_w[23:16] <= rx_b;
                    3'd3:    addr_w[31:24] <= rx_b;
                    3'd4:    len[7:0]      <= rx_b;
                    default: len[15:8]     <= rx_b;
                endcase
            end

            if (state == S_DATA && rx_fire) word[{cnt[1:0], 3'b000} +: 8] <= rx_b;

            if (state == S_BUS && bus.gnt_dma) begin
                addr_w <= addr_w + 1'b1;
                len    <= len - 16'd1;
            end
        end
    end

    assign bus.rx_tready = (state == S_IDLE) || in_frame;
    assign bus.tx_tvalid = (state == S_RESP);
    assign bus.tx_tdata  = tx_byte;
    assign bus.req_dma   = (state == S_BUS);
    assign bus.dma_write = (state == S_BUS);
    assign bus.dma_read  = 1'b0;
    assign bus.dma_size  = 4'b1111;
    assign bus.dma_addr  = {addr_w, 2'b00};
    assign bus.dma_din   = word;
    assign busy          = (state != S_IDLE);
endmodule
